// File: rtl/tsl235r_period_avg.sv
// rtl/tsl235r_period_avg.sv - windowed average of TSL235R high time and period
//
// Purpose:
//   Samples the pulse-width detector's hi_time/lo_time once every SAMPLE_DIV
//   ref_clk cycles. A sample is kept only when both captures are non-zero.
//   After 2^LOG2_N kept samples, it publishes the mean period (hi+lo) and the
//   mean high time on a valid/ready handshake. A sticky overrun flag records
//   any result that was replaced before it was consumed.
//
// Optional feature macro: TSL_PERIOD_MINMAX_EN
//   When defined, the block also reports the minimum and maximum saturated
//   period seen over each window (min_period/max_period). These outputs load
//   together with avg_period.
//
// Ports:
//   ref_clk     in   1        reference clock, shared with the detector
//   reset       in   1        synchronous, active-high
//   hi_time     in   TIME_W   latest high duration (ref_clk cycles)
//   lo_time     in   TIME_W   latest low duration (ref_clk cycles)
//   avg_period  out  TIME_W   mean of hi+lo over the window, saturated
//   avg_hi      out  TIME_W   mean of hi_time over the window
//   avg_valid   out  1        result available
//   avg_ready   in   1        consumer takes the result on avg_valid&avg_ready
//   overrun     out  1        sticky, set when an unconsumed result is replaced
//   sample_cnt  out  LOG2_N   kept samples in the current window
//   min_period  out  TIME_W   (TSL_PERIOD_MINMAX_EN) window minimum period
//   max_period  out  TIME_W   (TSL_PERIOD_MINMAX_EN) window maximum period

module tsl235r_period_avg #(
   parameter int TIME_W     = 32,
   parameter int LOG2_N     = 3,
   parameter int SAMPLE_DIV = 1000
) (
   input  logic              ref_clk,
   input  logic              reset,
   input  logic [TIME_W-1:0] hi_time,
   input  logic [TIME_W-1:0] lo_time,
   output logic [TIME_W-1:0] avg_period,
   output logic [TIME_W-1:0] avg_hi,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              overrun,
`ifdef TSL_PERIOD_MINMAX_EN
   output logic [TIME_W-1:0] min_period,
   output logic [TIME_W-1:0] max_period,
`endif
   output logic [LOG2_N-1:0] sample_cnt
);

   localparam int ACCP_W = TIME_W + 1 + LOG2_N;
   localparam int ACCH_W = TIME_W + LOG2_N;
   localparam int TMR_W  = $clog2(SAMPLE_DIV);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_DIV - 1);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_LOAD  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [ACCP_W-1:0] acc_p_q, acc_p_d;
   logic [ACCH_W-1:0] acc_h_q, acc_h_d;
   logic [LOG2_N-1:0] cnt_q, cnt_d;
   logic [TIME_W-1:0] avg_period_q, avg_period_d;
   logic [TIME_W-1:0] avg_hi_q, avg_hi_d;
   logic              avg_valid_q, avg_valid_d;
   logic              overrun_q, overrun_d;

   // Datapath helpers
   logic              tick;
   logic              sample_ok;
   logic              load_en;
   logic [TIME_W:0]   psum;
   logic [ACCP_W-1:0] acc_p_sum;
   logic [ACCH_W-1:0] acc_h_sum;
   logic [TIME_W:0]   per_shift;
   logic [TIME_W-1:0] per_sat;
   logic [TIME_W-1:0] hi_mean;

   assign tick      = (timer_q == '0);
   assign sample_ok = tick && (hi_time != '0) && (lo_time != '0);
   // The last sample of a window completes it; results load on this same edge
   // so avg_valid follows the final tick by exactly one cycle.
   assign load_en   = sample_ok && (cnt_q == {LOG2_N{1'b1}});

   assign psum      = {1'b0, hi_time} + {1'b0, lo_time};
   assign acc_p_sum = acc_p_q + ACCP_W'(psum);
   assign acc_h_sum = acc_h_q + ACCH_W'(hi_time);
   assign per_shift = acc_p_sum[ACCP_W-1:LOG2_N];
   assign per_sat   = per_shift[TIME_W] ? {TIME_W{1'b1}} : per_shift[TIME_W-1:0];
   assign hi_mean   = acc_h_sum[ACCH_W-1:LOG2_N];

`ifdef TSL_PERIOD_MINMAX_EN
   logic [TIME_W-1:0] trk_min_q, trk_min_d;
   logic [TIME_W-1:0] trk_max_q, trk_max_d;
   logic [TIME_W-1:0] min_out_q, min_out_d;
   logic [TIME_W-1:0] max_out_q, max_out_d;
   logic [TIME_W-1:0] psum_sat;
   logic [TIME_W-1:0] min_cand;
   logic [TIME_W-1:0] max_cand;

   assign psum_sat = psum[TIME_W] ? {TIME_W{1'b1}} : psum[TIME_W-1:0];
   assign min_cand = (psum_sat < trk_min_q) ? psum_sat : trk_min_q;
   assign max_cand = (psum_sat > trk_max_q) ? psum_sat : trk_max_q;

   always_comb begin
      trk_min_d = trk_min_q;
      trk_max_d = trk_max_q;
      min_out_d = min_out_q;
      max_out_d = max_out_q;
      if (load_en) begin
         min_out_d = min_cand;
         max_out_d = max_cand;
         trk_min_d = {TIME_W{1'b1}};
         trk_max_d = '0;
      end else if (sample_ok) begin
         trk_min_d = min_cand;
         trk_max_d = max_cand;
      end
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         trk_min_q <= {TIME_W{1'b1}};
         trk_max_q <= '0;
         min_out_q <= '0;
         max_out_q <= '0;
      end else begin
         trk_min_q <= trk_min_d;
         trk_max_q <= trk_max_d;
         min_out_q <= min_out_d;
         max_out_q <= max_out_d;
      end
   end

   assign min_period = min_out_q;
   assign max_period = max_out_q;
`endif

   // Window FSM: LOAD marks the single cycle following a result load. The
   // sample path never waits on it, so loads ignore back-pressure.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM: if (load_en) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_ACCUM;
         default:  state_d = ST_ACCUM;
      endcase
   end

   always_comb begin
      timer_d      = tick ? TMR_RELOAD : (timer_q - TMR_W'(1));
      acc_p_d      = acc_p_q;
      acc_h_d      = acc_h_q;
      cnt_d        = cnt_q;
      avg_period_d = avg_period_q;
      avg_hi_d     = avg_hi_q;
      avg_valid_d  = avg_valid_q;
      overrun_d    = overrun_q;

      if (load_en) begin
         acc_p_d      = '0;
         acc_h_d      = '0;
         cnt_d        = '0;
         avg_period_d = per_sat;
         avg_hi_d     = hi_mean;
         avg_valid_d  = 1'b1;
         // A same-cycle handshake consumes the old result, so only an
         // unaccepted one counts as lost.
         if (avg_valid_q && !avg_ready) begin
            overrun_d = 1'b1;
         end
      end else begin
         if (sample_ok) begin
            acc_p_d = acc_p_sum;
            acc_h_d = acc_h_sum;
            cnt_d   = cnt_q + LOG2_N'(1);
         end
         if (avg_valid_q && avg_ready) begin
            avg_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state_q      <= ST_ACCUM;
         timer_q      <= TMR_RELOAD;
         acc_p_q      <= '0;
         acc_h_q      <= '0;
         cnt_q        <= '0;
         avg_period_q <= '0;
         avg_hi_q     <= '0;
         avg_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         acc_p_q      <= acc_p_d;
         acc_h_q      <= acc_h_d;
         cnt_q        <= cnt_d;
         avg_period_q <= avg_period_d;
         avg_hi_q     <= avg_hi_d;
         avg_valid_q  <= avg_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign avg_period = avg_period_q;
   assign avg_hi     = avg_hi_q;
   assign avg_valid  = avg_valid_q;
   assign overrun    = overrun_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_tsl235r_period_avg.sv
// tb/tb_tsl235r_period_avg.sv - directed scoreboard bench for tsl235r_period_avg

module tb_tsl235r_period_avg;

   localparam int TIME_W     = 32;
   localparam int LOG2_N     = 2;
   localparam int SAMPLE_DIV = 4;

   logic              ref_clk = 1'b0;
   logic              reset = 1'b1;
   logic [TIME_W-1:0] hi_time = '0;
   logic [TIME_W-1:0] lo_time = '0;
   logic              avg_ready = 1'b0;
   logic [TIME_W-1:0] avg_period;
   logic [TIME_W-1:0] avg_hi;
   logic              avg_valid;
   logic              overrun;
   logic [LOG2_N-1:0] sample_cnt;
`ifdef TSL_PERIOD_MINMAX_EN
   logic [TIME_W-1:0] min_period;
   logic [TIME_W-1:0] max_period;
`endif

   tsl235r_period_avg #(
      .TIME_W(TIME_W),
      .LOG2_N(LOG2_N),
      .SAMPLE_DIV(SAMPLE_DIV)
   ) dut (
      .ref_clk(ref_clk),
      .reset(reset),
      .hi_time(hi_time),
      .lo_time(lo_time),
      .avg_period(avg_period),
      .avg_hi(avg_hi),
      .avg_valid(avg_valid),
      .avg_ready(avg_ready),
      .overrun(overrun),
`ifdef TSL_PERIOD_MINMAX_EN
      .min_period(min_period),
      .max_period(max_period),
`endif
      .sample_cnt(sample_cnt)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct packed {
      logic [TIME_W-1:0] period;
      logic [TIME_W-1:0] hi;
   } res_t;

   res_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge ref_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic check_result(input string tag);
      res_t r;
      chk({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         r = exp_q.pop_front();
         chk({tag, "_valid"}, 32'(avg_valid), 32'd1);
         chk({tag, "_period"}, avg_period, r.period);
         chk({tag, "_hi"}, avg_hi, r.hi);
      end
   endtask

   // Waits (bounded) for avg_valid, checking the cycle count to get there.
   task automatic wait_valid(input string tag, input int exp_cycles);
      int c = 0;
      while (!avg_valid && c < 200) begin
         step(1);
         c++;
      end
      chk({tag, "_latency"}, 32'(c), 32'(exp_cycles));
      check_result(tag);
   endtask

   initial begin
      // Reset state and basic window: 100/300 constant, no consumer
      hi_time = 32'd100;
      lo_time = 32'd300;
      do_reset();
      chk("rst_valid", 32'(avg_valid), 32'd0);
      chk("rst_period", avg_period, 32'd0);
      chk("rst_hi", avg_hi, 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_cnt", 32'(sample_cnt), 32'd0);
      exp_q.push_back('{period: 32'd400, hi: 32'd100});
      step(12);
      chk("t1_cnt3", 32'(sample_cnt), 32'd3);
      chk("t1_not_yet", 32'(avg_valid), 32'd0);
      wait_valid("t1", 4);
      chk("t1_overrun", 32'(overrun), 32'd0);
      chk("t1_cnt_clr", 32'(sample_cnt), 32'd0);
      avg_ready = 1'b1;
      step(1);
      avg_ready = 1'b0;
      chk("t1_consumed", 32'(avg_valid), 32'd0);

      // Incomplete captures skipped for two ticks
      lo_time = 32'd0;
      do_reset();
      step(4);
      chk("t2_skip1", 32'(sample_cnt), 32'd0);
      step(4);
      chk("t2_skip2", 32'(sample_cnt), 32'd0);
      lo_time = 32'd300;
      exp_q.push_back('{period: 32'd400, hi: 32'd100});
      wait_valid("t2", 16);

      // Saturated period
      hi_time = 32'hFFFF_FFFF;
      lo_time = 32'hFFFF_FFFF;
      do_reset();
      exp_q.push_back('{period: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFF});
      wait_valid("t3", 16);

      // Overwrite while unconsumed -> overrun; then handshake
      hi_time = 32'd100;
      lo_time = 32'd300;
      do_reset();
      exp_q.push_back('{period: 32'd400, hi: 32'd100});
      wait_valid("t4a", 16);
      hi_time = 32'd200;
      lo_time = 32'd200;
      exp_q.push_back('{period: 32'd400, hi: 32'd200});
      step(15);
      chk("t4_hold_valid", 32'(avg_valid), 32'd1);
      chk("t4_hold_hi", avg_hi, 32'd100);
      chk("t4_no_overrun", 32'(overrun), 32'd0);
      step(1);
      check_result("t4b");
      chk("t4_overrun", 32'(overrun), 32'd1);
      avg_ready = 1'b1;
      step(1);
      avg_ready = 1'b0;
      chk("t4_consumed", 32'(avg_valid), 32'd0);
      chk("t4_overrun_sticky", 32'(overrun), 32'd1);

      // Reset mid-window discards partial sums
      hi_time = 32'd100;
      lo_time = 32'd300;
      do_reset();
      step(12);
      chk("t5_cnt3", 32'(sample_cnt), 32'd3);
      do_reset();
      chk("t5_rst_cnt", 32'(sample_cnt), 32'd0);
      chk("t5_rst_overrun", 32'(overrun), 32'd0);
      chk("t5_rst_valid", 32'(avg_valid), 32'd0);
      hi_time = 32'd50;
      lo_time = 32'd150;
      exp_q.push_back('{period: 32'd200, hi: 32'd50});
      wait_valid("t5", 16);

`ifdef TSL_PERIOD_MINMAX_EN
      // Min/max tracking over periods 400,380,420,400
      hi_time = 32'd100;
      lo_time = 32'd300;
      do_reset();
      chk("t6_rst_min", min_period, 32'd0);
      chk("t6_rst_max", max_period, 32'd0);
      step(4);
      lo_time = 32'd280;
      step(4);
      lo_time = 32'd320;
      step(4);
      lo_time = 32'd300;
      exp_q.push_back('{period: 32'd400, hi: 32'd100});
      wait_valid("t6", 4);
      chk("t6_min", min_period, 32'd380);
      chk("t6_max", max_period, 32'd420);
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
